// File: rtl/ram_rd_streamer.sv
// ram_rd_streamer
//   Read-side sequencer for a single-port RAM with a 1-cycle synchronous read.
//   A start command reads len_i consecutive words beginning at start_addr_i and
//   presents them as a valid/ready stream with a last marker. A 3-entry skid
//   FIFO absorbs the RAM read latency and downstream backpressure.
//
// Ports
//   clk_i          clock, all logic on the rising edge
//   rst_ni         synchronous active-low reset
//   start_i        command strobe, only looked at while idle
//   start_addr_i   first word address (wraps modulo 2^ADDR_WIDTH)
//   len_i          number of words to read (0 gives an empty transfer)
//   busy_o         high from the cycle after an accepted start until done
//   done_o         one-cycle completion pulse
//   mem_ce_o       RAM chip enable, one read issued per high cycle
//   mem_we_o       RAM byte write enables, always zero
//   mem_addr_o     RAM address
//   mem_dout_i     RAM read data, valid the cycle after mem_ce_o
//   out_valid_o    stream beat valid
//   out_data_o     stream beat data
//   out_last_o     final beat of the transfer
//   out_ready_i    downstream accept
module ram_rd_streamer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 9
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic [ADDR_WIDTH-1:0]   start_addr_i,
    input  logic [LEN_WIDTH-1:0]    len_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    mem_ce_o,
    output logic [DATA_WIDTH/8-1:0] mem_we_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    input  logic [DATA_WIDTH-1:0]   mem_dout_i,
    output logic                    out_valid_o,
    output logic [DATA_WIDTH-1:0]   out_data_o,
    output logic                    out_last_o,
    input  logic                    out_ready_i
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  rdAddr_q, rdAddr_d;
    logic [LEN_WIDTH-1:0]   issueCnt_q, issueCnt_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic                   inflight_q;
    logic                   inflightLast_q;

    logic [DATA_WIDTH-1:0]  fifoData_q [3];
    logic                   fifoLast_q [3];
    logic [1:0]             wrPtr_q;
    logic [1:0]             rdPtr_q;
    logic [1:0]             count_q;

    logic                   issue;
    logic                   lastIssue;
    logic                   push;
    logic                   pop;
    logic                   headLast;

    // Credit rule: words already in the FIFO plus the read in flight must leave
    // room for the one about to be issued, so the FIFO can never overflow even
    // when downstream stalls. Deliberately ignores out_ready_i so mem_ce_o has
    // no combinational path from the stream side.
    assign issue     = (state_q == RUN) &&
                       (({1'b0, count_q} + {2'b00, inflight_q}) < 3'd3);
    assign lastIssue = issue && (issueCnt_q == (len_q - LEN_WIDTH'(1)));
    assign push      = inflight_q;
    assign pop       = (count_q != 2'd0) && out_ready_i;
    assign headLast  = fifoLast_q[rdPtr_q];

    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == FIN);
    assign mem_ce_o    = issue;
    assign mem_we_o    = '0;
    assign mem_addr_o  = rdAddr_q;
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = fifoData_q[rdPtr_q];
    // Slots keep stale last tags after popping, so gate with valid.
    assign out_last_o  = out_valid_o && headLast;

    // Next-state logic for the transfer sequencer.
    always_comb begin
        state_d    = state_q;
        rdAddr_d   = rdAddr_q;
        issueCnt_d = issueCnt_q;
        len_d      = len_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    len_d      = len_i;
                    rdAddr_d   = start_addr_i;
                    issueCnt_d = '0;
                    state_d    = (len_i == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (issue) begin
                    rdAddr_d   = rdAddr_q + ADDR_WIDTH'(1);
                    issueCnt_d = issueCnt_q + LEN_WIDTH'(1);
                    if (lastIssue) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && headLast) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer registers and the read-in-flight tracking.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            rdAddr_q       <= '0;
            issueCnt_q     <= '0;
            len_q          <= '0;
            inflight_q     <= 1'b0;
            inflightLast_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rdAddr_q       <= rdAddr_d;
            issueCnt_q     <= issueCnt_d;
            len_q          <= len_d;
            inflight_q     <= issue;
            inflightLast_q <= lastIssue;
        end
    end

    // Skid FIFO: capture only when a read is in flight, never relying on the
    // RAM holding its output.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < 3; i++) begin
                fifoData_q[i] <= '0;
                fifoLast_q[i] <= 1'b0;
            end
            wrPtr_q <= 2'd0;
            rdPtr_q <= 2'd0;
            count_q <= 2'd0;
        end else begin
            if (push) begin
                fifoData_q[wrPtr_q] <= mem_dout_i;
                fifoLast_q[wrPtr_q] <= inflightLast_q;
                wrPtr_q             <= (wrPtr_q == 2'd2) ? 2'd0 : wrPtr_q + 2'd1;
            end
            if (pop) begin
                rdPtr_q <= (rdPtr_q == 2'd2) ? 2'd0 : rdPtr_q + 2'd1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // The credit rule makes these unreachable; they guard against regressions.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(push && !pop && (count_q == 2'd3)));
            assert (!(pop && (count_q == 2'd0)));
        end
    end

endmodule
